// File: rtl/pipeline_controller.sv
// Hazard/stall/flush controller for a five-stage pipeline with a bounded memory-wait FSM.
// Optional performance counters (stall_cnt, flush_cnt, wait_cnt) are built when PIPE_CTRL_PERF_EN is defined.
module pipeline_controller #(
  parameter int MAX_WAIT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       IDEX_MemRead,
  input  logic [4:0] IDEX_Rt,
  input  logic [4:0] IFID_Rs,
  input  logic [4:0] IFID_Rt,
  input  logic       branch_taken,
  input  logic       jump,
  input  logic       mem_req,
  input  logic       mem_ready,
  output logic       PC_we,
  output logic [1:0] PC_sel,
  output logic       IFID_en,
  output logic       IDEX_en,
  output logic       EXMEM_en,
  output logic       MEMWB_en,
  output logic       IFID_flush,
  output logic       IDEX_bubble,
  output logic [1:0] state_o,
  output logic       error
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt,
  output logic [31:0] wait_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    RUN      = 2'b01,
    MEM_WAIT = 2'b10,
    ERROR    = 2'b11
  } state_e;

  localparam int CW = $clog2(MAX_WAIT + 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          active;
  logic          freeze;
  logic          load_use;
  logic          stall;

  assign active   = (state_q == RUN) || (state_q == MEM_WAIT);
  assign freeze   = active && mem_req && !mem_ready;
  assign load_use = IDEX_MemRead && (IDEX_Rt != 5'd0) &&
                    ((IDEX_Rt == IFID_Rs) || (IDEX_Rt == IFID_Rt));
  assign stall    = active && !freeze && load_use;

  assign state_o  = state_q;
  assign error    = (state_q == ERROR);

  // NOTE: non-blocking assignments in clocked blocks so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // NOTE: every output gets a default first so no path through the block infers a latch.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    PC_we       = 1'b0;
    PC_sel      = 2'b00;
    IFID_en     = 1'b0;
    IDEX_en     = 1'b0;
    EXMEM_en    = 1'b0;
    MEMWB_en    = 1'b0;
    IFID_flush  = 1'b0;
    IDEX_bubble = 1'b0;

    case (state_q)
      IDLE: if (start) state_d = RUN;
      RUN: begin
        if (freeze) begin
          state_d = (MAX_WAIT <= 1) ? ERROR : MEM_WAIT;
          cnt_d   = CW'(1);
        end
      end
      MEM_WAIT: begin
        if (freeze) begin
          // The counter holds the number of frozen cycles seen so far.
          if (cnt_q >= CW'(MAX_WAIT - 1)) state_d = ERROR;
          cnt_d = cnt_q + CW'(1);
        end else begin
          state_d = RUN;
          cnt_d   = '0;
        end
      end
      ERROR: ;
    endcase

    // The exit cycle of MEM_WAIT is treated exactly like a RUN cycle.
    if (active && !freeze) begin
      PC_we    = 1'b1;
      IFID_en  = 1'b1;
      IDEX_en  = 1'b1;
      EXMEM_en = 1'b1;
      MEMWB_en = 1'b1;
      if (load_use) begin
        PC_we       = 1'b0;
        IFID_en     = 1'b0;
        IDEX_bubble = 1'b1;
      end else if (jump) begin
        PC_sel     = 2'b10;
        IFID_flush = 1'b1;
      end else if (branch_taken) begin
        PC_sel     = 2'b11;
        IFID_flush = 1'b1;
      end
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stall_cnt_q, flush_cnt_q, wait_cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
      wait_cnt_q  <= '0;
    end else begin
      if (stall && (stall_cnt_q != '1))      stall_cnt_q <= stall_cnt_q + 32'd1;
      if (IFID_flush && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + 32'd1;
      if (freeze && (wait_cnt_q != '1))      wait_cnt_q  <= wait_cnt_q + 32'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
  assign wait_cnt  = wait_cnt_q;
`else
  logic unused_stall;
  assign unused_stall = stall;
`endif

endmodule

// File: tb/tb_pipeline_controller.sv
// Directed bench for pipeline_controller (MAX_WAIT=4); checks wait_cnt when PIPE_CTRL_PERF_EN is defined.
module tb_pipeline_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, IDEX_MemRead, branch_taken, jump, mem_req, mem_ready;
  logic [4:0] IDEX_Rt, IFID_Rs, IFID_Rt;
  logic       PC_we, IFID_en, IDEX_en, EXMEM_en, MEMWB_en, IFID_flush, IDEX_bubble, error;
  logic [1:0] PC_sel, state_o;
`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stall_cnt, flush_cnt, wait_cnt;
`endif

  int vectors    = 0;
  int miscompares = 0;

  // {PC_we, PC_sel, IFID/IDEX/EXMEM/MEMWB_en, IFID_flush, IDEX_bubble, state_o, error}
  logic [11:0] obs;
  assign obs = {PC_we, PC_sel, IFID_en, IDEX_en, EXMEM_en, MEMWB_en,
                IFID_flush, IDEX_bubble, state_o, error};

  localparam logic [11:0] IDLE_OFF    = {1'b0, 2'b00, 4'b0000, 1'b0, 1'b0, 2'b00, 1'b0};
  localparam logic [11:0] RUN_NORM    = {1'b1, 2'b00, 4'b1111, 1'b0, 1'b0, 2'b01, 1'b0};
  localparam logic [11:0] STALL       = {1'b0, 2'b00, 4'b0111, 1'b0, 1'b1, 2'b01, 1'b0};
  localparam logic [11:0] JUMP        = {1'b1, 2'b10, 4'b1111, 1'b1, 1'b0, 2'b01, 1'b0};
  localparam logic [11:0] BRANCH      = {1'b1, 2'b11, 4'b1111, 1'b1, 1'b0, 2'b01, 1'b0};
  localparam logic [11:0] FROZEN_RUN  = {1'b0, 2'b00, 4'b0000, 1'b0, 1'b0, 2'b01, 1'b0};
  localparam logic [11:0] FROZEN_WAIT = {1'b0, 2'b00, 4'b0000, 1'b0, 1'b0, 2'b10, 1'b0};
  localparam logic [11:0] WAIT_EXIT_J = {1'b1, 2'b10, 4'b1111, 1'b1, 1'b0, 2'b10, 1'b0};
  localparam logic [11:0] ERR         = {1'b0, 2'b00, 4'b0000, 1'b0, 1'b0, 2'b11, 1'b1};

  pipeline_controller #(.MAX_WAIT(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .IDEX_MemRead (IDEX_MemRead),
    .IDEX_Rt      (IDEX_Rt),
    .IFID_Rs      (IFID_Rs),
    .IFID_Rt      (IFID_Rt),
    .branch_taken (branch_taken),
    .jump         (jump),
    .mem_req      (mem_req),
    .mem_ready    (mem_ready),
    .PC_we        (PC_we),
    .PC_sel       (PC_sel),
    .IFID_en      (IFID_en),
    .IDEX_en      (IDEX_en),
    .EXMEM_en     (EXMEM_en),
    .MEMWB_en     (MEMWB_en),
    .IFID_flush   (IFID_flush),
    .IDEX_bubble  (IDEX_bubble),
    .state_o      (state_o),
    .error        (error)
`ifdef PIPE_CTRL_PERF_EN
    ,
    .stall_cnt    (stall_cnt),
    .flush_cnt    (flush_cnt),
    .wait_cnt     (wait_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Advance one rising edge and return to the falling edge, where inputs change.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    start = 0; IDEX_MemRead = 0; IDEX_Rt = 0; IFID_Rs = 0; IFID_Rt = 0;
    branch_taken = 0; jump = 0; mem_req = 0; mem_ready = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b0;
    start = 1'b1;
    #1;
    vectors++;
    if (obs !== IDLE_OFF) begin
      miscompares++;
      $display("FAIL reset_async obs=%b exp=%b", obs, IDLE_OFF);
    end
    step();
    vectors++;
    if (obs !== IDLE_OFF) begin
      miscompares++;
      $display("FAIL reset_held_start obs=%b exp=%b", obs, IDLE_OFF);
    end
    rst = 1'b1;
    start = 1'b1;
    #1;
    vectors++;
    if (obs !== IDLE_OFF) begin
      miscompares++;
      $display("FAIL idle_before_edge obs=%b exp=%b", obs, IDLE_OFF);
    end
    step();
    start = 1'b0;
    #1;
    vectors++;
    if (obs !== RUN_NORM) begin
      miscompares++;
      $display("FAIL start_to_run obs=%b exp=%b", obs, RUN_NORM);
    end
  endtask

  task automatic test_load_use();
    IDEX_MemRead = 1; IDEX_Rt = 5'd5; IFID_Rs = 5'd5; IFID_Rt = 5'd1;
    #1;
    vectors++;
    if (obs !== STALL) begin
      miscompares++;
      $display("FAIL stall_rs obs=%b exp=%b", obs, STALL);
    end
    step();
    IDEX_MemRead = 0;
    #1;
    vectors++;
    if (obs !== RUN_NORM) begin
      miscompares++;
      $display("FAIL stall_one_cycle obs=%b exp=%b", obs, RUN_NORM);
    end
    IDEX_MemRead = 1; IDEX_Rt = 5'd0; IFID_Rs = 5'd0; IFID_Rt = 5'd0;
    #1;
    vectors++;
    if (obs !== RUN_NORM) begin
      miscompares++;
      $display("FAIL stall_rt_zero obs=%b exp=%b", obs, RUN_NORM);
    end
    step();
    IDEX_Rt = 5'd7; IFID_Rs = 5'd3; IFID_Rt = 5'd7;
    #1;
    vectors++;
    if (obs !== STALL) begin
      miscompares++;
      $display("FAIL stall_rt_match obs=%b exp=%b", obs, STALL);
    end
    step();
    IFID_Rt = 5'd8;
    #1;
    vectors++;
    if (obs !== RUN_NORM) begin
      miscompares++;
      $display("FAIL no_match obs=%b exp=%b", obs, RUN_NORM);
    end
    step();
    clear_inputs();
  endtask

  task automatic test_redirect();
    IDEX_MemRead = 1; IDEX_Rt = 5'd9; IFID_Rs = 5'd9; branch_taken = 1;
    #1;
    vectors++;
    if (obs !== STALL) begin
      miscompares++;
      $display("FAIL stall_over_branch obs=%b exp=%b", obs, STALL);
    end
    jump = 1;
    #1;
    vectors++;
    if (obs !== STALL) begin
      miscompares++;
      $display("FAIL stall_over_jump obs=%b exp=%b", obs, STALL);
    end
    step();
    IDEX_MemRead = 0;
    #1;
    vectors++;
    if (obs !== JUMP) begin
      miscompares++;
      $display("FAIL jump_over_branch obs=%b exp=%b", obs, JUMP);
    end
    step();
    jump = 0;
    #1;
    vectors++;
    if (obs !== BRANCH) begin
      miscompares++;
      $display("FAIL branch_only obs=%b exp=%b", obs, BRANCH);
    end
    step();
    clear_inputs();
  endtask

  task automatic test_mem_wait();
    mem_req = 1; mem_ready = 0;
    #1;
    vectors++;
    if (obs !== FROZEN_RUN) begin
      miscompares++;
      $display("FAIL freeze_in_run obs=%b exp=%b", obs, FROZEN_RUN);
    end
    step();
    // A load-use hazard during freeze must not produce a bubble.
    IDEX_MemRead = 1; IDEX_Rt = 5'd4; IFID_Rs = 5'd4;
    #1;
    vectors++;
    if (obs !== FROZEN_WAIT) begin
      miscompares++;
      $display("FAIL freeze_wait2 obs=%b exp=%b", obs, FROZEN_WAIT);
    end
    step();
    IDEX_MemRead = 0;
    #1;
    vectors++;
    if (obs !== FROZEN_WAIT) begin
      miscompares++;
      $display("FAIL freeze_wait3 obs=%b exp=%b", obs, FROZEN_WAIT);
    end
    step();
    mem_ready = 1; jump = 1;
    #1;
    vectors++;
    if (obs !== WAIT_EXIT_J) begin
      miscompares++;
      $display("FAIL wait_exit_jump obs=%b exp=%b", obs, WAIT_EXIT_J);
    end
    step();
    clear_inputs();
    #1;
    vectors++;
    if (obs !== RUN_NORM) begin
      miscompares++;
      $display("FAIL back_to_run obs=%b exp=%b", obs, RUN_NORM);
    end
`ifdef PIPE_CTRL_PERF_EN
    vectors++;
    if (wait_cnt !== 32'd3) begin
      miscompares++;
      $display("FAIL wait_cnt obs=%0d exp=3", wait_cnt);
    end
`endif
  endtask

  task automatic test_timeout();
    mem_req = 1; mem_ready = 0;
    for (int i = 0; i < 3; i++) step();
    #1;
    vectors++;
    if (obs !== FROZEN_WAIT) begin
      miscompares++;
      $display("FAIL before_timeout obs=%b exp=%b", obs, FROZEN_WAIT);
    end
    step();
    #1;
    vectors++;
    if (obs !== ERR) begin
      miscompares++;
      $display("FAIL timeout_error obs=%b exp=%b", obs, ERR);
    end
    mem_req = 0; start = 1;
    step();
    #1;
    vectors++;
    if (obs !== ERR) begin
      miscompares++;
      $display("FAIL error_sticky obs=%b exp=%b", obs, ERR);
    end
    start = 0;
    #1;
    rst = 1'b0;
    #1;
    vectors++;
    if (obs !== IDLE_OFF) begin
      miscompares++;
      $display("FAIL error_async_clear obs=%b exp=%b", obs, IDLE_OFF);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset_mid_wait();
    start = 1;
    step();
    start = 0; mem_req = 1; mem_ready = 0;
    step();
    step();
    #1;
    vectors++;
    if (obs !== FROZEN_WAIT) begin
      miscompares++;
      $display("FAIL mid_wait_state obs=%b exp=%b", obs, FROZEN_WAIT);
    end
    rst = 1'b0;
    #1;
    vectors++;
    if (obs !== IDLE_OFF) begin
      miscompares++;
      $display("FAIL mid_wait_reset obs=%b exp=%b", obs, IDLE_OFF);
    end
`ifdef PIPE_CTRL_PERF_EN
    vectors++;
    if (wait_cnt !== 32'd0) begin
      miscompares++;
      $display("FAIL wait_cnt_reset obs=%0d exp=0", wait_cnt);
    end
`endif
    @(negedge clk);
    rst = 1'b1;
    clear_inputs();
    step();
    #1;
    vectors++;
    if (obs !== IDLE_OFF) begin
      miscompares++;
      $display("FAIL idle_after_release obs=%b exp=%b", obs, IDLE_OFF);
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_redirect();
    test_mem_wait();
    test_timeout();
    test_reset_mid_wait();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
